// File: rtl/parity_diff_stream.sv
// parity_diff_stream: streaming bit-difference encoder (inverse of prefix XOR)
// with packet framing, registered output stage and one-entry skid buffer.
module parity_diff_stream #(
  parameter int   p_WIDTH = 8,
  parameter logic p_INIT  = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [p_WIDTH-1:0] iwv_data,
  input  logic               i_sop,
  input  logic               i_eop,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [p_WIDTH-1:0] owv_data,
  output logic               o_sop,
  output logic               o_eop,
  output logic               o_proto_err
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_IN_PKT = 1'b1;

  logic [0:0]         r_state;
  logic               r_carry;
  logic               r_ready;
  logic               r_proto_err;

  logic               r_out_valid;
  logic [p_WIDTH-1:0] r_out_data;
  logic               r_out_sop;
  logic               r_out_eop;

  logic               r_sk_valid;
  logic [p_WIDTH-1:0] r_sk_data;
  logic               r_sk_sop;
  logic               r_sk_eop;

  logic               w_acc;
  logic               w_free;
  logic               w_idle;
  logic               w_first;
  logic               w_c;
  logic               w_err;
  logic               w_sk_next;
  logic [p_WIDTH-1:0] w_enc;

  assign w_acc   = i_valid && r_ready;
  assign w_free  = !r_out_valid || i_ready;
  assign w_idle  = (r_state == S_IDLE);
  // A beat arriving in IDLE always opens a packet, sop or not.
  assign w_first = i_sop || w_idle;
  assign w_c     = w_first ? p_INIT : r_carry;
  assign w_err   = w_acc && (w_idle ? !i_sop : i_sop);

  generate
    if (p_WIDTH == 1) begin : g_w1
      assign w_enc = iwv_data ^ w_c;
    end else begin : g_wn
      assign w_enc = iwv_data ^ {iwv_data[p_WIDTH-2:0], w_c};
    end
  endgenerate

  // Skid only fills when the output register is stuck; it empties on drain.
  assign w_sk_next = w_free ? 1'b0 : (r_sk_valid || w_acc);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_carry     <= p_INIT;
      r_proto_err <= 1'b0;
    end else begin
      r_proto_err <= w_err;
      if (w_acc) begin
        r_carry <= i_eop ? p_INIT : iwv_data[p_WIDTH-1];
        r_state <= i_eop ? S_IDLE : S_IN_PKT;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ready     <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_sk_valid  <= 1'b0;
      r_sk_data   <= '0;
      r_sk_sop    <= 1'b0;
      r_sk_eop    <= 1'b0;
    end else begin
      r_ready <= !w_sk_next;
      if (w_free) begin
        if (r_sk_valid) begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_sk_data;
          r_out_sop   <= r_sk_sop;
          r_out_eop   <= r_sk_eop;
          r_sk_valid  <= 1'b0;
        end else if (w_acc) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_enc;
          r_out_sop   <= w_first;
          r_out_eop   <= i_eop;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (w_acc) begin
        r_sk_valid <= 1'b1;
        r_sk_data  <= w_enc;
        r_sk_sop   <= w_first;
        r_sk_eop   <= i_eop;
      end
    end
  end

  assign o_ready     = r_ready;
  assign o_valid     = r_out_valid;
  assign owv_data    = r_out_data;
  assign o_sop       = r_out_sop;
  assign o_eop       = r_out_eop;
  assign o_proto_err = r_proto_err;

endmodule

// File: tb/tb_parity_diff_stream.sv
// tb_parity_diff_stream: directed framing/backpressure scenarios plus
// randomized round-trip against a prefix-XOR decoder for three variants.
module tb_parity_diff_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] v, rdy, isop, ieop;
  logic [2:0] ordy, ovld, osop, oeop, perr;
  logic [7:0] din [3];
  logic [7:0] d0, d2;
  logic [0:0] d1;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       s;
    logic       e;
    logic [7:0] d;
  } beat_t;

  parity_diff_stream #(.p_WIDTH(8), .p_INIT(1'b0)) u0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(v[0]), .o_ready(ordy[0]),
    .iwv_data(din[0]), .i_sop(isop[0]), .i_eop(ieop[0]),
    .o_valid(ovld[0]), .i_ready(rdy[0]), .owv_data(d0),
    .o_sop(osop[0]), .o_eop(oeop[0]), .o_proto_err(perr[0]));

  parity_diff_stream #(.p_WIDTH(1), .p_INIT(1'b1)) u1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(v[1]), .o_ready(ordy[1]),
    .iwv_data(din[1][0:0]), .i_sop(isop[1]), .i_eop(ieop[1]),
    .o_valid(ovld[1]), .i_ready(rdy[1]), .owv_data(d1),
    .o_sop(osop[1]), .o_eop(oeop[1]), .o_proto_err(perr[1]));

  parity_diff_stream #(.p_WIDTH(8), .p_INIT(1'b1)) u2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(v[2]), .o_ready(ordy[2]),
    .iwv_data(din[2]), .i_sop(isop[2]), .i_eop(ieop[2]),
    .o_valid(ovld[2]), .i_ready(rdy[2]), .owv_data(d2),
    .o_sop(osop[2]), .o_eop(oeop[2]), .o_proto_err(perr[2]));

  function automatic logic [7:0] od(int k);
    case (k)
      0:       return d0;
      1:       return {7'd0, d1};
      default: return d2;
    endcase
  endfunction

  task automatic drv(int k, logic [7:0] d, logic s, logic e);
    v[k] = 1'b1; din[k] = d; isop[k] = s; ieop[k] = e;
  endtask

  task automatic hush(int k);
    v[k] = 1'b0; din[k] = 8'h00; isop[k] = 1'b0; ieop[k] = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ovld[k], ordy[k], osop[k], oeop[k], perr[k], od(k)} !==
          {1'b0, 1'b1, 3'b000, 8'h00}) begin
        errors++;
        $display("FAIL reset_state[%0d] got v%b r%b s%b e%b p%b d%h want v0 r1 s0 e0 p0 d00",
          k, ovld[k], ordy[k], osop[k], oeop[k], perr[k], od(k));
      end
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    rdy[0] = 1'b1;
    @(negedge clk); drv(0, 8'h01, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if ({ovld[0], osop[0], oeop[0], d0} !== {3'b110, 8'h03}) begin
      errors++;
      $display("FAIL basic_b0 got %h want %h", {ovld[0], osop[0], oeop[0], d0}, {3'b110, 8'h03});
    end
    drv(0, 8'h80, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if ({ovld[0], osop[0], oeop[0], d0} !== {3'b100, 8'h80}) begin
      errors++;
      $display("FAIL basic_b1 got %h want %h", {ovld[0], osop[0], oeop[0], d0}, {3'b100, 8'h80});
    end
    drv(0, 8'hFF, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if ({ovld[0], osop[0], oeop[0], d0} !== {3'b101, 8'h00}) begin
      errors++;
      $display("FAIL basic_b2 got %h want %h", {ovld[0], osop[0], oeop[0], d0}, {3'b101, 8'h00});
    end
    hush(0);
    @(negedge clk);
    checks++;
    if (ovld[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle o_valid got %b want 0", ovld[0]);
    end
  endtask

  task automatic test_single();
    @(negedge clk); drv(0, 8'h55, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if ({ovld[0], osop[0], oeop[0], d0} !== {3'b111, 8'hFF}) begin
      errors++;
      $display("FAIL single_55 got %h want %h", {ovld[0], osop[0], oeop[0], d0}, {3'b111, 8'hFF});
    end
    drv(0, 8'hFF, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if ({ovld[0], osop[0], oeop[0], d0} !== {3'b111, 8'h01}) begin
      errors++;
      $display("FAIL single_ff got %h want %h", {ovld[0], osop[0], oeop[0], d0}, {3'b111, 8'h01});
    end
    hush(0);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    rdy[0] = 1'b0;
    @(negedge clk); drv(0, 8'h01, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if ({ordy[0], ovld[0], osop[0], d0} !== {3'b111, 8'h03}) begin
      errors++;
      $display("FAIL bp_first got %h want %h", {ordy[0], ovld[0], osop[0], d0}, {3'b111, 8'h03});
    end
    drv(0, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if ({ordy[0], ovld[0], d0} !== {2'b01, 8'h03}) begin
      errors++;
      $display("FAIL bp_skid_full got %h want %h", {ordy[0], ovld[0], d0}, {2'b01, 8'h03});
    end
    drv(0, 8'h04, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if ({ordy[0], ovld[0], osop[0], d0} !== {3'b011, 8'h03}) begin
      errors++;
      $display("FAIL bp_hold got %h want %h", {ordy[0], ovld[0], osop[0], d0}, {3'b011, 8'h03});
    end
    rdy[0] = 1'b1;
    @(negedge clk);
    checks++;
    if ({ordy[0], ovld[0], osop[0], oeop[0], d0} !== {4'b1100, 8'h06}) begin
      errors++;
      $display("FAIL bp_rel1 got %h want %h", {ordy[0], ovld[0], osop[0], oeop[0], d0}, {4'b1100, 8'h06});
    end
    @(negedge clk);
    checks++;
    if ({ovld[0], osop[0], oeop[0], d0} !== {3'b101, 8'h0C}) begin
      errors++;
      $display("FAIL bp_rel2 got %h want %h", {ovld[0], osop[0], oeop[0], d0}, {3'b101, 8'h0C});
    end
    hush(0);
    @(negedge clk);
    checks++;
    if (ovld[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty o_valid got %b want 0", ovld[0]);
    end
  endtask

  task automatic test_proto_err();
    rdy[0] = 1'b1;
    @(negedge clk); drv(0, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if ({perr[0], ovld[0], osop[0], d0} !== {3'b111, 8'h03}) begin
      errors++;
      $display("FAIL perr_nosop got %h want %h", {perr[0], ovld[0], osop[0], d0}, {3'b111, 8'h03});
    end
    drv(0, 8'h80, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if ({perr[0], ovld[0], osop[0], d0} !== {3'b010, 8'h80}) begin
      errors++;
      $display("FAIL perr_pulse_once got %h want %h", {perr[0], ovld[0], osop[0], d0}, {3'b010, 8'h80});
    end
    drv(0, 8'hFF, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if ({perr[0], ovld[0], osop[0], oeop[0], d0} !== {4'b1111, 8'h01}) begin
      errors++;
      $display("FAIL perr_midsop got %h want %h", {perr[0], ovld[0], osop[0], oeop[0], d0}, {4'b1111, 8'h01});
    end
    hush(0);
    @(negedge clk);
    checks++;
    if ({perr[0], ovld[0]} !== 2'b00) begin
      errors++;
      $display("FAIL perr_clear got %b want 00", {perr[0], ovld[0]});
    end
  endtask

  task automatic test_reset_midpkt();
    rdy[0] = 1'b0;
    @(negedge clk); drv(0, 8'h01, 1'b1, 1'b0);
    @(negedge clk); drv(0, 8'h80, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if ({ordy[0], ovld[0]} !== 2'b01) begin
      errors++;
      $display("FAIL rst_pre_full got %b want 01", {ordy[0], ovld[0]});
    end
    hush(0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ordy[0], ovld[0]} !== 2'b10) begin
      errors++;
      $display("FAIL rst_async got %b want 10", {ordy[0], ovld[0]});
    end
    @(negedge clk); rst_n = 1'b1; rdy[0] = 1'b1;
    @(negedge clk); drv(0, 8'hFF, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if ({perr[0], ovld[0], osop[0], oeop[0], d0} !== {4'b1111, 8'h01}) begin
      errors++;
      $display("FAIL rst_fresh_nosop got %h want %h", {perr[0], ovld[0], osop[0], oeop[0], d0}, {4'b1111, 8'h01});
    end
    drv(0, 8'hFF, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if ({perr[0], ovld[0], osop[0], oeop[0], d0} !== {4'b0111, 8'h01}) begin
      errors++;
      $display("FAIL rst_fresh_sop got %h want %h", {perr[0], ovld[0], osop[0], oeop[0], d0}, {4'b0111, 8'h01});
    end
    hush(0);
    @(negedge clk);
  endtask

  task automatic test_random(int k, int w, logic init);
    beat_t      in_q[$];
    beat_t      out_q[$];
    beat_t      b, held;
    logic [7:0] mask, dec;
    logic       prev, perr_seen, hold_pend;
    int         idx, len;
    mask = 8'((1 << w) - 1);
    for (int p = 0; p < 30; p++) begin
      len = $urandom_range(1, 5);
      for (int j = 0; j < len; j++) begin
        b.d = 8'($urandom) & mask;
        b.s = (j == 0);
        b.e = (j == len - 1);
        in_q.push_back(b);
      end
    end
    idx = 0; perr_seen = 1'b0; hold_pend = 1'b0; held = '0;
    for (int cyc = 0; cyc < 3000 && out_q.size() < in_q.size(); cyc++) begin
      @(negedge clk);
      perr_seen = perr_seen | perr[k];
      if (hold_pend) begin
        checks++;
        if ({ovld[k], osop[k], oeop[k], od(k)} !== {1'b1, held}) begin
          errors++;
          $display("FAIL rnd%0d_hold got %h want %h", k, {ovld[k], osop[k], oeop[k], od(k)}, {1'b1, held});
        end
      end
      if (idx < in_q.size() && ($urandom_range(0, 3) != 0))
        drv(k, in_q[idx].d, in_q[idx].s, in_q[idx].e);
      else
        hush(k);
      rdy[k] = ($urandom_range(0, 2) != 0);
      if (v[k] && ordy[k]) idx++;
      if (ovld[k] && rdy[k]) out_q.push_back({osop[k], oeop[k], od(k)});
      hold_pend = ovld[k] && !rdy[k];
      held = {osop[k], oeop[k], od(k)};
    end
    hush(k); rdy[k] = 1'b1;
    @(negedge clk);
    checks++;
    if (out_q.size() != in_q.size()) begin
      errors++;
      $display("FAIL rnd%0d_count got %0d want %0d", k, out_q.size(), in_q.size());
    end
    checks++;
    if (perr_seen !== 1'b0) begin
      errors++;
      $display("FAIL rnd%0d_proto_err got %b want 0", k, perr_seen);
    end
    prev = init;
    for (int j = 0; j < out_q.size() && j < in_q.size(); j++) begin
      if (out_q[j].s) prev = init;
      dec = 8'h00;
      for (int i = 0; i < w; i++) begin
        dec[i] = out_q[j].d[i] ^ prev;
        prev = dec[i];
      end
      checks++;
      if ({out_q[j].s, out_q[j].e, dec} !== in_q[j]) begin
        errors++;
        $display("FAIL rnd%0d_beat%0d got %h want %h", k, j, {out_q[j].s, out_q[j].e, dec}, in_q[j]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    v = '0; rdy = 3'b111; isop = '0; ieop = '0;
    for (int k = 0; k < 3; k++) din[k] = 8'h00;
    test_reset();
    test_basic();
    test_single();
    test_backpressure();
    test_proto_err();
    test_reset_midpkt();
    test_random(0, 8, 1'b0);
    test_random(1, 1, 1'b1);
    test_random(2, 8, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parity_diff_stream.md
Name: parity_diff_stream

Overview:
- Streaming inverse of the block's parity-prefix operator. Each output bit is the XOR of an input bit and the bit before it: out[i] = in[i] ^ in[i-1].
- The predecessor of bit 0 is the last bit of the previously accepted word in the same packet, so a packet encoded here and then prefix-XORed (with carry) is restored exactly.
- Sits on a valid/ready word stream with packet framing. Registered output stage plus skid buffer, full throughput.

Parameters:
- p_WIDTH, 8, data word width in bits; must be greater than zero. Bit 0 is first in stream order, bit p_WIDTH-1 is last.
- p_INIT, 1'b0, carry value used as the predecessor of bit 0 of the first word of every packet.

Ports:
- i_clk  input  1  clock; all state on the rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  upstream beat valid.
- o_ready  output  1  upstream may transfer; registered.
- iwv_data  input  p_WIDTH  upstream word.
- i_sop  input  1  first beat of packet; qualified by i_valid.
- i_eop  input  1  last beat of packet; qualified by i_valid.
- o_valid  output  1  downstream beat valid.
- i_ready  input  1  downstream accepts.
- owv_data  output  p_WIDTH  difference-encoded word.
- o_sop  output  1  sop travelling with owv_data.
- o_eop  output  1  eop travelling with owv_data.
- o_proto_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (asynchronous assert, synchronous release): o_valid=0, owv_data=0, o_sop=0, o_eop=0, o_proto_err=0, o_ready=1, skid empty, carry=p_INIT, FSM=IDLE.
- Accept: a beat transfers in when i_valid && o_ready. It leaves when o_valid && i_ready.
- Encoding of an accepted beat, with c = (i_sop || FSM==IDLE) ? p_INIT : carry:
  - out[0] = in[0] ^ c
  - out[i] = in[i] ^ in[i-1] for 1 <= i < p_WIDTH
  - With p_WIDTH=1: out[0] = in[0] ^ c.
- Carry update on accept: carry <= i_eop ? p_INIT : in[p_WIDTH-1].
- FSM states and transitions:
  - IDLE --accept, !i_eop--> IN_PKT.
  - IDLE --accept, i_eop--> IDLE (single-beat packet).
  - IN_PKT --accept, i_eop--> IDLE.
  - Otherwise the state holds.
- Framing errors (data is still processed):
  - Accept in IDLE without i_sop: treated as sop; o_proto_err pulses the next cycle; o_sop forced to 1 on that output beat.
  - Accept in IN_PKT with i_sop: packet restarts, carry=p_INIT; o_proto_err pulses the next cycle.
  - Error cases do not stall the stream.
- Latency: a beat accepted in cycle N is presented in cycle N+1 when the output stage is empty or draining in cycle N.
- Output stage plus one-entry skid register:
  - o_ready = !skid_full, registered.
  - When the output register is full with i_ready=0 and a beat is accepted, that beat goes to skid; o_ready drops the next cycle.
  - On drain, skid moves into the output register before any new beat.
  - Ordering is strictly preserved.
- Stability: while o_valid && !i_ready, owv_data, o_sop and o_eop hold constant.
- Throughput: one beat per cycle sustained while i_ready=1.
- Simultaneous drain and accept in the same cycle: no bubble and no drop.
- Reset mid-packet: all in-flight beats discarded, carry=p_INIT, FSM=IDLE. The next beat encodes as a fresh packet (with o_proto_err if it lacks sop).
- Carry is committed at accept time, independent of downstream backpressure.

Test Plan:
- p_WIDTH=8, p_INIT=0, i_ready=1. Packet 0x01(sop), 0x80, 0xFF(eop) -> owv_data 0x03, 0x80, 0x00 on consecutive cycles, each 1 cycle after accept; o_sop on the first beat, o_eop on the last.
- Single beat 0x55 with sop+eop -> 0xFF. Next single beat 0xFF with sop+eop -> 0x01 (carry restored to p_INIT after eop).
- Backpressure: i_ready=0 for 3 cycles while sending 0x01(sop), 0x02, 0x04(eop) -> o_ready falls after 2 accepted beats, owv_data holds 0x03. On release: 0x03, 0x06, 0x0C in order, no loss.
- Framing errors:
  - Beat 0x01 without sop in IDLE -> o_proto_err pulses once; output 0x03 with o_sop=1.
  - Mid-packet sop on 0xFF after 0x80 -> output 0x01 (carry 0, not 1); o_proto_err pulses.
- Reset asserted mid-packet with the skid full -> o_valid=0 and o_ready=1 immediately. After release, 0xFF(sop) -> 0x01.
- Randomized round-trip: random packets with random i_valid/i_ready; a prefix-XOR model with carry applied to the output must equal the input stream; p_WIDTH=1 and p_INIT=1 variants included.
